// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage cpu port and the dbg loader port.
// Default: cpu priority with a starvation counter; `define DM_ARB_RR_EN for round-robin instead.
module dm_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [31:0]   dbg_rdata,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata
);

  logic        cpu_req, dbg_pend, cpu_grant, dbg_grant;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic        dbg_ack_q, dbg_ack_d;

  assign cpu_req  = cpu_rd | cpu_wr;
  // dbg_req is still held during its ack cycle; that cycle must not re-grant the same request.
  assign dbg_pend = dbg_req & ~dbg_ack_q;

`ifdef DM_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 0 = cpu, 1 = dbg

  always_comb begin
    cpu_grant    = 1'b0;
    dbg_grant    = 1'b0;
    last_grant_d = last_grant_q;
    if (cpu_req && dbg_pend) begin
      if (last_grant_q) cpu_grant = 1'b1;
      else              dbg_grant = 1'b1;
    end else if (cpu_req) begin
      cpu_grant = 1'b1;
    end else if (dbg_pend) begin
      dbg_grant = 1'b1;
    end
    if (dbg_grant)      last_grant_d = 1'b1;
    else if (cpu_grant) last_grant_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end
`else
  typedef enum logic {CPU_PRI, DBG_FORCE} state_e;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    cpu_grant  = 1'b0;
    dbg_grant  = 1'b0;
    state_d    = CPU_PRI;
    wait_cnt_d = 4'd0;
    if (state_q == DBG_FORCE && dbg_pend) dbg_grant = 1'b1;
    else if (cpu_req)                     cpu_grant = 1'b1;
    else if (dbg_pend)                    dbg_grant = 1'b1;
    // Count denied cycles; the cycle after the count reaches MAX_WAIT dbg is forced through.
    if (dbg_pend && !dbg_grant) begin
      wait_cnt_d = (wait_cnt_q >= MAX_W) ? MAX_W : wait_cnt_q + 4'd1;
      if (wait_cnt_d >= MAX_W) state_d = DBG_FORCE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CPU_PRI;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  always_comb begin
    dm_addr  = '0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_wdata = 32'd0;
    if (cpu_grant) begin
      dm_addr  = cpu_addr;
      dm_wr    = cpu_wr;
      dm_rd    = cpu_rd & ~cpu_wr;  // rd+wr together behaves as a write
      dm_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      dm_addr  = dbg_addr;
      dm_wr    = dbg_we;
      dm_rd    = ~dbg_we;
      dm_wdata = dbg_wdata;
    end
  end

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_ack_d   = dbg_grant;
    if (cpu_grant && cpu_rd && !cpu_wr) cpu_rdata_d = dm_rdata;
    if (dbg_grant && !dbg_we)           dbg_rdata_d = dm_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
      dbg_ack_q   <= 1'b0;
    end else begin
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_grant;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_ack   = dbg_ack_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dm_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst;
  logic cpu_rd, cpu_wr, cpu_stall, dbg_req, dbg_we, dbg_ack, dm_rd, dm_wr;
  logic [AW-1:0] cpu_addr, dbg_addr, dm_addr;
  logic [31:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, dm_wdata, dm_rdata;

  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

  dm_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  task automatic idle;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = 32'd0;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1; idle;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (cpu_rdata !== 32'd0) begin failures++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
    checks++; if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL reset_dbg_rdata got %h want 0", dbg_rdata); end
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_dbg_ack got %b want 0", dbg_ack); end
    checks++; if ({cpu_stall, dm_rd, dm_wr} !== 3'b000) begin failures++; $display("FAIL reset_idle_ctrl got %b want 000", {cpu_stall, dm_rd, dm_wr}); end
    checks++; if (dm_addr !== '0 || dm_wdata !== 32'd0) begin failures++; $display("FAIL reset_idle_bus got %h/%h want 0/0", dm_addr, dm_wdata); end
  endtask

  task automatic fill_mem;
    logic [31:0] d;
    for (int a = 0; a < 128; a++) begin
      @(negedge clk); idle;
      d = $urandom; cpu_wr = 1'b1; cpu_addr = 7'(a); cpu_wdata = d; ref_mem[a] = d;
      #1;
      checks++; if (cpu_stall !== 1'b0 || dm_wr !== 1'b1) begin failures++; $display("FAIL fill_write got stall=%b wr=%b want 0/1", cpu_stall, dm_wr); end
    end
    @(negedge clk); idle;
  endtask

  task automatic test_cpu_wr_rd;
    @(negedge clk); idle; cpu_wr = 1'b1; cpu_addr = 7'd5; cpu_wdata = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    #1;
    checks++; if ({dm_wr, dm_rd, cpu_stall} !== 3'b100 || dm_addr !== 7'd5 || dm_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL cpu_write got wr/rd/stall=%b addr=%h data=%h want 100/05/deadbeef", {dm_wr, dm_rd, cpu_stall}, dm_addr, dm_wdata); end
    @(negedge clk); cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    checks++; if ({dm_wr, dm_rd, cpu_stall} !== 3'b010 || dm_addr !== 7'd5) begin
      failures++; $display("FAIL cpu_read got wr/rd/stall=%b addr=%h want 010/05", {dm_wr, dm_rd, cpu_stall}, dm_addr); end
    @(negedge clk); idle;
    #1;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_rdata got %h want deadbeef", cpu_rdata); end
    checks++; if (dm_wr !== 1'b0) begin failures++; $display("FAIL cpu_wr_one_cycle got %b want 0", dm_wr); end
  endtask

  task automatic test_dbg_alone;
    @(negedge clk); idle; cpu_wr = 1'b1; cpu_addr = 7'h7F; cpu_wdata = 32'h12345678; ref_mem[127] = 32'h12345678;
    @(negedge clk); idle; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h7F;
    #1;
    checks++; if ({dm_rd, dm_wr, dbg_ack} !== 3'b100 || dm_addr !== 7'h7F) begin
      failures++; $display("FAIL dbg_grant got rd/wr/ack=%b addr=%h want 100/7f", {dm_rd, dm_wr, dbg_ack}, dm_addr); end
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h12345678) begin
      failures++; $display("FAIL dbg_ack_data got ack=%b data=%h want 1/12345678", dbg_ack, dbg_rdata); end
    checks++; if (dm_rd !== 1'b0) begin failures++; $display("FAIL dbg_no_regrant got dm_rd=%b want 0", dm_rd); end
    dbg_req = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_pulse got %b want 0", dbg_ack); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); idle; cpu_rd = 1'b1; cpu_addr = 7'd5;
    @(negedge clk); idle; dbg_req = 1'b1; dbg_addr = 7'h7F; rst = 1'b1;
    #1;
    checks++; if (cpu_rdata !== 32'hDEADBEEF || dm_rd !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got rdata=%h rd=%b want deadbeef/1", cpu_rdata, dm_rd); end
    @(negedge clk); rst = 1'b0; idle;
    #1;
    checks++; if (dbg_ack !== 1'b0 || cpu_rdata !== 32'd0 || dbg_rdata !== 32'd0) begin
      failures++; $display("FAIL rstmid_post got ack=%b crd=%h drd=%h want 0/0/0", dbg_ack, cpu_rdata, dbg_rdata); end
  endtask

`ifndef DM_ARB_RR_EN
  task automatic test_starvation;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin idle; cpu_rd = 1'b1; cpu_addr = 7'd10; dbg_req = 1'b1; dbg_addr = 7'd20; end
      #1;
      checks++; if (cpu_stall !== (c == 5) || dbg_ack !== (c == 6)) begin
        failures++; $display("FAIL starve_c%0d got stall=%b ack=%b want %b/%b", c, cpu_stall, dbg_ack, c == 5, c == 6); end
      checks++; if (dm_addr !== ((c == 5) ? 7'd20 : 7'd10) || dm_rd !== 1'b1) begin
        failures++; $display("FAIL starve_addr_c%0d got %h rd=%b", c, dm_addr, dm_rd); end
      if (c == 2) begin
        checks++; if (cpu_rdata !== ref_mem[10]) begin failures++; $display("FAIL starve_cpu_rdata got %h want %h", cpu_rdata, ref_mem[10]); end
      end
      if (c == 6) begin
        checks++; if (dbg_rdata !== ref_mem[20]) begin failures++; $display("FAIL starve_dbg_rdata got %h want %h", dbg_rdata, ref_mem[20]); end
        dbg_req = 1'b0;
      end
    end
    @(negedge clk); idle;
    #1;
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL starve_ack_end got %b want 0", dbg_ack); end
  endtask
`else
  task automatic test_rr_alternate;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin idle; cpu_rd = 1'b1; cpu_addr = 7'd10; dbg_addr = 7'd20; end
      if (c == 2) dbg_req = 1'b1;
      if (c == 7) idle;
      #1;
      if (c <= 6) begin
        checks++; if (cpu_stall !== (c % 2 == 0) || dm_addr !== ((c % 2 == 0) ? 7'd20 : 7'd10)) begin
          failures++; $display("FAIL rr_c%0d got stall=%b addr=%h", c, cpu_stall, dm_addr); end
      end
      checks++; if (dbg_ack !== (c == 3 || c == 5 || c == 7)) begin
        failures++; $display("FAIL rr_ack_c%0d got %b", c, dbg_ack); end
    end
  endtask
`endif

  task automatic test_contention;
    @(negedge clk); idle; dbg_req = 1'b1; dbg_addr = 7'd0;
    @(negedge clk); idle;
    #1;
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL cont_pre_ack got %b want 1", dbg_ack); end
    @(negedge clk);
    cpu_wr = 1'b1; cpu_addr = 7'd3; cpu_wdata = 32'hA;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'd3; dbg_wdata = 32'hB;
    #1;
    checks++; if (cpu_stall !== 1'b0 || dm_wr !== 1'b1 || dm_wdata !== 32'hA) begin
      failures++; $display("FAIL cont_cpu_first got stall=%b wr=%b data=%h want 0/1/a", cpu_stall, dm_wr, dm_wdata); end
    @(negedge clk); cpu_wr = 1'b0;
    #1;
    checks++; if (dm_wr !== 1'b1 || dm_wdata !== 32'hB || dm_addr !== 7'd3) begin
      failures++; $display("FAIL cont_dbg_second got wr=%b data=%h addr=%h want 1/b/03", dm_wr, dm_wdata, dm_addr); end
    @(negedge clk); dbg_req = 1'b0; dbg_we = 1'b0; cpu_rd = 1'b1; cpu_addr = 7'd3;
    #1;
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL cont_dbg_ack got %b want 1", dbg_ack); end
    @(negedge clk); idle;
    #1;
    ref_mem[3] = 32'hB;
    checks++; if (cpu_rdata !== 32'hB || mem[3] !== 32'hB) begin
      failures++; $display("FAIL cont_final got rdata=%h mem=%h want b/b", cpu_rdata, mem[3]); end
  endtask

  task automatic test_random;
    logic exp_ack, last_dbg, stalled, dbg_busy, dbg_p, g_dbg, g_cpu, c_req, erd, ewr;
    logic [31:0] exp_crd, exp_drd, ewd;
    logic [6:0] ea;
    int waited, run, bad, bound;
    int unsigned r;
    exp_ack = 1'b0; last_dbg = 1'b0; stalled = 1'b0; dbg_busy = 1'b0;
    exp_crd = 32'd0; exp_drd = 32'd0; waited = 0; run = 0; bad = 0;
`ifdef DM_ARB_RR_EN
    bound = 1;
`else
    bound = MAX_WAIT;
`endif
    @(negedge clk); rst = 1'b1; idle;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      checks++; if (dbg_ack !== exp_ack || cpu_rdata !== exp_crd || dbg_rdata !== exp_drd) begin
        failures++; $display("FAIL rand_regs i=%0d got ack=%b crd=%h drd=%h want %b/%h/%h", i, dbg_ack, cpu_rdata, dbg_rdata, exp_ack, exp_crd, exp_drd); end
      if (!stalled) begin
        r = $urandom_range(0, 7);
        cpu_rd = (r >= 2 && r <= 4) || r == 7;
        cpu_wr = (r >= 5);
        cpu_addr = 7'($urandom); cpu_wdata = $urandom;
      end
      if (exp_ack) dbg_busy = 1'b0;
      else if (dbg_busy && $urandom_range(0, 15) == 0) dbg_busy = 1'b0;
      if (!dbg_busy && $urandom_range(0, 2) == 0) begin
        dbg_busy = 1'b1; dbg_we = 1'($urandom); dbg_addr = 7'($urandom); dbg_wdata = $urandom;
      end
      dbg_req = dbg_busy;
      #1;
      c_req = cpu_rd | cpu_wr;
      dbg_p = dbg_req && !exp_ack;
`ifdef DM_ARB_RR_EN
      g_dbg = dbg_p && (!c_req || !last_dbg);
`else
      g_dbg = dbg_p && (!c_req || waited >= MAX_WAIT);
`endif
      g_cpu = c_req && !g_dbg;
      ea = 7'd0; erd = 1'b0; ewr = 1'b0; ewd = 32'd0;
      if (g_cpu) begin ea = cpu_addr; ewr = cpu_wr; erd = !cpu_wr; ewd = cpu_wdata; end
      if (g_dbg) begin ea = dbg_addr; ewr = dbg_we; erd = !dbg_we; ewd = dbg_wdata; end
      checks++; if (cpu_stall !== (c_req && !g_cpu) || dm_rd !== erd || dm_wr !== ewr || dm_addr !== ea) begin
        failures++; $display("FAIL rand_bus i=%0d got stall=%b rd=%b wr=%b addr=%h want %b/%b/%b/%h", i, cpu_stall, dm_rd, dm_wr, dm_addr, c_req && !g_cpu, erd, ewr, ea); end
      if (ewr) begin
        checks++; if (dm_wdata !== ewd) begin failures++; $display("FAIL rand_wdata i=%0d got %h want %h", i, dm_wdata, ewd); end
      end
      run = (dbg_p && !g_dbg) ? run + 1 : 0;
      checks++; if (run > bound) begin failures++; $display("FAIL rand_starve i=%0d waited %0d cycles, limit %0d", i, run, bound); end
      waited = (dbg_p && !g_dbg) ? ((waited + 1 > MAX_WAIT) ? MAX_WAIT : waited + 1) : 0;
      if (g_dbg) last_dbg = 1'b1; else if (g_cpu) last_dbg = 1'b0;
      if (g_cpu && cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
      if (g_cpu && !cpu_wr) exp_crd = ref_mem[cpu_addr];
      if (g_dbg && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      if (g_dbg && !dbg_we) exp_drd = ref_mem[dbg_addr];
      exp_ack = g_dbg;
      stalled = c_req && !g_cpu;
      @(negedge clk);
    end
    idle;
    checks++; if (dbg_ack !== exp_ack || cpu_rdata !== exp_crd) begin
      failures++; $display("FAIL rand_last got ack=%b crd=%h want %b/%h", dbg_ack, cpu_rdata, exp_ack, exp_crd); end
    @(negedge clk);
    for (int a = 0; a < 128; a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_mem got %0d differing words want 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    idle;
    repeat (2) @(negedge clk);
    test_reset;
    fill_mem;
    test_cpu_wr_rd;
    test_dbg_alone;
    test_reset_mid;
`ifndef DM_ARB_RR_EN
    test_starvation;
`else
    test_rr_alternate;
`endif
    test_contention;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (dm, 128 x 32-bit words, word address [6:0]) between two requesters: the pipeline MEM stage (cpu port) and an external loader/debug port (dbg port).
- Sits between stage4_mem and dm. Asserts cpu_stall when the MEM-stage access is deferred so the hazard logic freezes stages 1-4.
- The CPU has priority by default. A starvation counter guarantees dbg progress.

Parameters:
- MAX_WAIT, 4: consecutive cycles dbg may be denied before it is force-granted; legal 1..15.
- AW, 7: word-address width; must match dm.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- cpu_rd  in  1  MEM-stage read request (memread)
- cpu_wr  in  1  MEM-stage write request (memwrite)
- cpu_addr  in  AW  MEM-stage word address (alurslt[8:2])
- cpu_wdata  in  32  MEM-stage write data
- cpu_rdata  out  32  registered read data for the MEM/WB latch
- cpu_stall  out  1  CPU request not served this cycle
- dbg_req  in  1  debug access request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug word address
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  one-cycle pulse, cycle after grant
- dbg_rdata  out  32  read data, valid with dbg_ack
- dm_addr  out  AW  to dm addr
- dm_rd  out  1  to dm rd
- dm_wr  out  1  to dm wr
- dm_wdata  out  32  to dm wdata
- dm_rdata  in  32  from dm rdata; combinational read of dm_addr

Behaviour:
- Reset: one clk edge with rst=1. All registered outputs go to 0: cpu_rdata, dbg_ack, dbg_rdata, wait counter. State goes to CPU_PRI. rst overrides everything, including an in-flight grant (no ack is issued for it).
- cpu_req = cpu_rd | cpu_wr. cpu_rd & cpu_wr together is illegal; treat it as a write.
- States:
  - CPU_PRI: cpu_req wins. Otherwise a pending dbg_req wins.
  - DBG_FORCE: dbg wins even if cpu_req is high. Entered when wait_cnt reaches MAX_WAIT with dbg_req high. Always lasts exactly one cycle, then returns to CPU_PRI.
- Grant is combinational in the current cycle.
  - dm_* is driven from the granted requester.
  - With no grant, dm_rd = dm_wr = 0 and dm_addr/dm_wdata = 0.
- cpu_stall = cpu_req & ~cpu_grant (combinational). While stalled, the CPU holds its request unchanged.
- wait_cnt (4 bits):
  - increments each cycle dbg_req=1 and dbg is not granted;
  - clears on dbg grant or when dbg_req=0;
  - saturates at MAX_WAIT.
- Latency:
  - cpu read: cpu_rdata <= dm_rdata on the granted edge, usable by WB next cycle. With no cpu read grant, cpu_rdata holds its value.
  - dbg: dbg_ack=1 on the cycle after grant; for reads, dbg_rdata is captured at the grant edge. dbg_ack is never high for two consecutive cycles for one request. The bench must see dbg_req drop or re-present after ack.
  - Writes: commit at the grant edge (dm is written on clk).
- Boundaries:
  - Simultaneous cpu/dbg requests in CPU_PRI: cpu served, dbg waits.
  - dbg_req withdrawn before grant: no access; wait_cnt clears.
  - Address wrap: no checking; AW bits pass through unchanged.
  - dbg_req rising in the same cycle as ack completion: treated as a new request.

Optional Feature:
- Macro DM_ARB_RR_EN.
- Defined: CPU_PRI is replaced by round-robin. A 1-bit last_grant register (reset 0 = cpu) gives priority to the requester not granted last. MAX_WAIT and DBG_FORCE are removed; dbg waits at most 1 cycle.
- Undefined: fixed CPU priority with the starvation counter, as above.

Test Plan:
- Reset mid-access: dbg_req=1 granted, rst=1 next edge -> dbg_ack=0, cpu_rdata=0, state CPU_PRI, wait_cnt=0.
- CPU write then read: cpu_wr addr 5 data 0xDEADBEEF, then cpu_rd addr 5 -> dm_wr high 1 cycle; cpu_rdata=0xDEADBEEF one edge after the read grant; cpu_stall=0 throughout.
- dbg alone: dbg_req read addr 0x7F (preloaded 0x12345678) -> dm_rd in grant cycle, dbg_ack and dbg_rdata=0x12345678 next cycle.
- Starvation: cpu_rd held continuously, dbg_req held, MAX_WAIT=4 -> dbg granted on cycle 5, cpu_stall=1 exactly that cycle, dbg_ack cycle 6.
- Contention ordering: same-cycle cpu_wr addr 3=0xA and dbg write addr 3=0xB -> cpu first, dbg later; final mem[3]=0xB.
- DM_ARB_RR_EN: both requesters continuously active -> grants alternate cpu, dbg, cpu, dbg; cpu_stall toggles 0,1,0,1.
